dilated_tap_cache: RTL and testbench

- Multi-channel, parametrised activation cache for one dilated causal conv layer.
- Keeps per-channel history of accepted samples in a circular buffer.
- On each accepted input vector, presents K dilated taps per channel to the downstream MAC stage.
- Over a fixed 4-tap cache, adds: kernel size, channel count, valid/ready handshake, zero-clear state machine after reset, and a `primed` flag once history is full.

---
 rtl/dilated_cache_pkg.sv | 19 +
 rtl/dilated_tap_cache_if.sv | 19 +
 rtl/tap_ring_mem.sv | 30 +++
 rtl/dilated_tap_cache.sv | 118 +++++++++++
 tb/tb_dilated_tap_cache.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/dilated_cache_pkg.sv
// Shared types and index helpers for the dilated tap cache.
//   state_t   : controller states (CLEAR zero-fills history, RUN streams)
//   wrap_sub  : (head - offset) mod depth without negative intermediates
//   tap_slice : bit offset of tap k, channel c in a packed tap vector
package dilated_cache_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  // offset never exceeds depth, so one conditional add of depth is enough
  function automatic int wrap_sub(input int head, input int offset, input int depth);
    if (head < offset) return head + depth - offset;
    return head - offset;
  endfunction

  function automatic int tap_slice(input int k, input int c, input int nch, input int w);
    return (k * nch + c) * w;
  endfunction

endpackage

// File: rtl/dilated_tap_cache_if.sv
// Stream bus between the producer, the tap cache and the downstream MAC.
//   in_valid/in_ready/inp : input vector handshake, channel c at inp[c*W +: W]
//   out_valid/out         : one-cycle pulse with K*C taps, tap k ch c at (k*C+c)*W
//   primed                : history is full, all taps hold real samples
interface dilated_tap_cache_if #(
  parameter int W = 16,
  parameter int C = 4,
  parameter int K = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [C*W-1:0]   inp;
  logic             out_valid;
  logic [K*C*W-1:0] out;
  logic             primed;

  modport master (output in_valid, inp, input in_ready, out_valid, out, primed);
  modport slave  (input in_valid, inp, output in_ready, out_valid, out, primed);
endinterface

// File: rtl/tap_ring_mem.sv
// History storage: DEPTH words of DW bits, one synchronous write port and
// NRD asynchronous read ports (registers / distributed RAM).
//   clk         : write clock
//   we/waddr/wdata : write port
//   raddr/rdata : NRD packed read ports, port r at [r*AW +: AW] / [r*DW +: DW]
module tap_ring_mem #(
  parameter int DEPTH = 6,
  parameter int DW    = 32,
  parameter int NRD   = 3,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign rdata[r*DW +: DW] = mem[raddr[r*AW +: AW]];
  end

endmodule

// File: rtl/dilated_tap_cache.sv
// Multi-channel activation cache for one dilated causal conv layer. Each
// accepted input vector is stored in a circular history and, one cycle
// later, K taps spaced DILATION samples apart are presented per channel.
//   clk, rst : clock and synchronous active-high reset (restarts zero-clear)
//   bus      : slave side of dilated_tap_cache_if
module dilated_tap_cache
  import dilated_cache_pkg::*;
#(
  parameter int W        = 16,
  parameter int C        = 4,
  parameter int K        = 4,
  parameter int DILATION = 16
) (
  input  logic                clk,
  input  logic                rst,
  dilated_tap_cache_if.slave  bus
);

  localparam int DEPTH = DILATION * (K - 1);
  localparam int AW    = $clog2(DEPTH) + 1;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = $clog2(DEPTH + 2);
  localparam int DW    = C * W;
  localparam int NRD   = K - 1;

  state_t state, state_nxt;
  logic [AW-1:0]     clr_addr;
  logic [AW-1:0]     write_head;
  logic [FW-1:0]     fill;
  logic              ready_p0;
  logic              accept;
  logic              we;
  logic [MAW-1:0]    waddr;
  logic [DW-1:0]     wdata;
  logic [NRD*MAW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [K*C*W-1:0]  taps_p0;
  logic [K*C*W-1:0]  out_p1;
  logic              vld_p1;
  logic              primed_p1;

  assign accept = bus.in_valid && ready_p0;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = write_head[MAW-1:0];
    wdata     = bus.inp;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr[MAW-1:0];
        wdata = '0;
        if (clr_addr == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: we = accept;
      default: state_nxt = CLEAR;
    endcase
  end

  tap_ring_mem #(.DEPTH(DEPTH), .DW(DW), .NRD(NRD), .AW(MAW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Read port m-1 serves lag m; lag K-1 equals DEPTH and lands on write_head,
  // which still holds the oldest sample because the write happens at the edge.
  for (genvar m = 1; m <= NRD; m++) begin : g_raddr
    assign raddr[(m-1)*MAW +: MAW] = MAW'(wrap_sub(int'(write_head), m * DILATION, DEPTH));
  end

  // Stage p0: assemble taps from current input and pre-write history
  for (genvar k = 0; k < K; k++) begin : g_tap
    for (genvar c = 0; c < C; c++) begin : g_ch
      localparam int BASE = tap_slice(k, c, C, W);
      if (k == K - 1) begin : g_cur
        assign taps_p0[BASE +: W] = bus.inp[c*W +: W];
      end else begin : g_hist
        assign taps_p0[BASE +: W] = rdata[(K-2-k)*DW + c*W +: W];
      end
    end
  end

  // Stage p1: registered taps, valid pulse and primed flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      write_head <= '0;
      fill       <= '0;
      ready_p0   <= 1'b0;
      vld_p1     <= 1'b0;
      primed_p1  <= 1'b0;
      out_p1     <= '0;
    end else begin
      state    <= state_nxt;
      ready_p0 <= (state_nxt == RUN);
      vld_p1   <= accept;
      if (state == CLEAR) clr_addr <= clr_addr + AW'(1);
      if (accept) begin
        out_p1     <= taps_p0;
        primed_p1  <= (fill >= FW'(DEPTH));
        if (fill != FW'(DEPTH + 1)) fill <= fill + FW'(1);
        write_head <= (write_head == AW'(DEPTH - 1)) ? '0 : write_head + AW'(1);
      end
    end
  end

  assign bus.in_ready  = ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out       = out_p1;
  assign bus.primed    = primed_p1;

endmodule

// File: tb/tb_dilated_tap_cache.sv
module tb_dilated_tap_cache;

  localparam int W     = 16;
  localparam int C     = 2;
  localparam int K     = 4;
  localparam int DIL   = 2;
  localparam int DEPTH = DIL * (K - 1);
  localparam int OW    = K * C * W;
  localparam int HMAX  = 1024;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  always #5 clk = ~clk;

  dilated_tap_cache_if #(.W(W), .C(C), .K(K)) bus ();
  dilated_tap_cache #(.W(W), .C(C), .K(K), .DILATION(DIL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dilated_tap_cache_if #(.W(16), .C(1), .K(2)) bus_b ();
  dilated_tap_cache #(.W(16), .C(1), .K(2), .DILATION(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: full list of samples accepted since the last reset.
  logic [W-1:0]  hist [C][HMAX];
  int            n_acc;
  int            t_run;
  logic [OW-1:0] exp_out;
  logic          exp_primed;

  function automatic logic [OW-1:0] model_taps();
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < C; c++) begin
        int idx;
        idx = n_acc - 1 - (K - 1 - k) * DIL;
        r[(k*C+c)*W +: W] = (idx >= 0) ? hist[c][idx] : '0;
      end
    return r;
  endfunction

  function automatic logic [4*W-1:0] ch_taps(input logic [OW-1:0] v, input int c);
    return {v[(3*C+c)*W +: W], v[(2*C+c)*W +: W], v[(1*C+c)*W +: W], v[c*W +: W]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_acc = 0; t_run = 0; exp_out = '0; exp_primed = 1'b0;
    chk("rst_out", 128'(bus.out), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_primed", 128'(bus.primed), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
  endtask

  task automatic cycle(input logic v, input logic [C*W-1:0] d, output logic acc);
    logic exp_rdy;
    bus.in_valid = v;
    bus.inp = d;
    exp_rdy = (t_run >= DEPTH);
    chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk); #1;
    t_run++;
    if (acc && n_acc < HMAX) begin
      for (int c = 0; c < C; c++) hist[c][n_acc] = d[c*W +: W];
      n_acc++;
      exp_out = model_taps();
      exp_primed = (n_acc >= DEPTH + 1);
    end
    chk("out_valid", 128'(bus.out_valid), 128'(acc));
    chk("out", 128'(bus.out), 128'(exp_out));
    chk("primed", 128'(bus.primed), 128'(exp_primed));
  endtask

  int   n;
  logic acc;

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    bus.in_valid = 1'b0; bus.inp = '0;
    bus_b.in_valid = 1'b0; bus_b.inp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;

    // dense stream through wrap-around, in_valid high through CLEAR
    do_reset();
    n = 1;
    for (int cyc = 0; cyc < 60 && n <= 25; cyc++) begin
      cycle(1'b1, {16'(100 + n), 16'(n)}, acc);
      if (acc) begin
        if (n == 6) begin
          chk("n6_ch0", 128'(ch_taps(bus.out, 0)), 128'({16'd6, 16'd4, 16'd2, 16'd0}));
          chk("n6_primed", 128'(bus.primed), 128'(0));
        end
        if (n == 7) begin
          chk("n7_ch0", 128'(ch_taps(bus.out, 0)), 128'({16'd7, 16'd5, 16'd3, 16'd1}));
          chk("n7_ch1", 128'(ch_taps(bus.out, 1)), 128'({16'd107, 16'd105, 16'd103, 16'd101}));
          chk("n7_primed", 128'(bus.primed), 128'(1));
        end
        if (n == 25) begin
          chk("n25_ch0", 128'(ch_taps(bus.out, 0)), 128'({16'd25, 16'd23, 16'd21, 16'd19}));
          chk("n25_ch1", 128'(ch_taps(bus.out, 1)), 128'({16'd125, 16'd123, 16'd121, 16'd119}));
        end
        n++;
      end
    end
    chk("dense_done", 128'(n), 128'(26));

    // gapped stream: in_valid 1,0,0,1,...
    do_reset();
    n = 1;
    for (int i = 0; i < 80 && n <= 7; i++) begin
      cycle((i % 3) == 0, {16'(100 + n), 16'(n)}, acc);
      if (acc) n++;
    end
    chk("gap_n7_ch0", 128'(ch_taps(bus.out, 0)), 128'({16'd7, 16'd5, 16'd3, 16'd1}));
    chk("gap_n7_ch1", 128'(ch_taps(bus.out, 1)), 128'({16'd107, 16'd105, 16'd103, 16'd101}));

    // mid-stream reset after 10 samples
    do_reset();
    n = 1;
    for (int cyc = 0; cyc < 40 && n <= 10; cyc++) begin
      cycle(1'b1, {16'(100 + n), 16'(n)}, acc);
      if (acc) n++;
    end
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 20 && n == 0; cyc++) begin
      cycle(1'b1, {16'd150, 16'd50}, acc);
      if (acc) n = 1;
    end
    chk("mid_rst_accept", 128'(n), 128'(1));
    chk("mid_rst_ch0", 128'(ch_taps(bus.out, 0)), 128'({16'd50, 16'd0, 16'd0, 16'd0}));

    // randomized segments against the model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        cycle(($urandom_range(0, 3) != 0), 32'($urandom), acc);
    end

    // DEPTH=1 corner: K=2, C=1, DILATION=1
    rst_b = 1'b1;
    bus_b.in_valid = 1'b1;
    bus_b.inp = 16'd4;
    @(posedge clk); #1;
    rst_b = 1'b0;
    chk("b_rst_ready", 128'(bus_b.in_ready), 128'(0));
    chk("b_rst_out", 128'(bus_b.out), 128'(0));
    @(posedge clk); #1;
    chk("b_clear_no_vld", 128'(bus_b.out_valid), 128'(0));
    chk("b_ready", 128'(bus_b.in_ready), 128'(1));
    @(posedge clk); #1;
    chk("b_t4_vld", 128'(bus_b.out_valid), 128'(1));
    chk("b_t4_out", 128'(bus_b.out), 128'({16'd4, 16'd0}));
    chk("b_t4_primed", 128'(bus_b.primed), 128'(0));
    bus_b.inp = 16'd5;
    @(posedge clk); #1;
    chk("b_t5_out", 128'(bus_b.out), 128'({16'd5, 16'd4}));
    chk("b_t5_primed", 128'(bus_b.primed), 128'(1));
    bus_b.inp = 16'd6;
    @(posedge clk); #1;
    chk("b_t6_out", 128'(bus_b.out), 128'({16'd6, 16'd5}));
    chk("b_t6_primed", 128'(bus_b.primed), 128'(1));
    bus_b.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_idle_vld", 128'(bus_b.out_valid), 128'(0));
    chk("b_idle_out", 128'(bus_b.out), 128'({16'd6, 16'd5}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
